// File: rtl/ex_pipe_if.sv
// Issue/result handshake bundle between the issue stage and ex_pipe.
interface ex_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op;
    logic [DATA_W-1:0] rega;
    logic [DATA_W-1:0] regb;
    logic              wr_i;
    logic [ADDR_W-1:0] waddr_i;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] regc_data;
    logic [ADDR_W-1:0] regc_addr;
    logic              regc_wr;

    // Issue stage / result consumer side
    modport master (
        output in_valid, op, rega, regb, wr_i, waddr_i, out_ready,
        input  in_ready, out_valid, regc_data, regc_addr, regc_wr
    );

    // Execution pipe side
    modport slave (
        input  in_valid, op, rega, regb, wr_i, waddr_i, out_ready,
        output in_ready, out_valid, regc_data, regc_addr, regc_wr
    );
endinterface

// File: rtl/ex_pipe.sv
// Single-issue execute stage: one-cycle ALU ops with a registered result
// token, plus iterative MULTU/DIVU that write the HI/LO pair.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | accepting ops when the output slot is free or draining
// MUL    | shift-add multiply, one multiplier bit per cycle
// DIV    | restoring divide, one quotient bit per cycle
module ex_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic     clk,
    input  logic     rst,
    ex_pipe_if.slave bus
);
    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_LUI   = 4'd9;
    localparam logic [3:0] OP_SLT   = 4'd10;
    localparam logic [3:0] OP_SLTU  = 4'd11;
    localparam logic [3:0] OP_MULTU = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;
    localparam logic [3:0] OP_MFHI  = 4'd14;
    localparam logic [3:0] OP_MFLO  = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   opb_q, opb_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   regc_data_q, regc_data_d;
    logic [ADDR_W-1:0]   regc_addr_q, regc_addr_d;
    logic                regc_wr_q, regc_wr_d;

    logic                in_ready;
    logic                accept;
    logic                is_long;
    logic                last_iter;
    logic [DATA_W-1:0]   alu_res;
    logic [SH_W-1:0]     shamt;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_shifted;
    logic                div_ge;
    logic [DATA_W-1:0]   div_rem;

    // FSM state register; reset also aborts any in-flight MUL/DIV
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: long ops enter MUL/DIV, leave on the last iteration
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && bus.op == OP_MULTU) begin
                    state_d = S_MUL;
                end else if (accept && bus.op == OP_DIVU) begin
                    state_d = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: handshake and iteration control
    always_comb begin
        in_ready  = !rst && (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
        accept    = bus.in_valid && in_ready;
        is_long   = (bus.op == OP_MULTU) || (bus.op == OP_DIVU);
        last_iter = (state_q != S_IDLE) && (cnt_q == CNT_W'(1));
    end

    // Single-cycle ALU result
    always_comb begin
        shamt   = bus.regb[SH_W-1:0];
        alu_res = '0;
        case (bus.op)
            OP_ADD:  alu_res = bus.rega + bus.regb;
            OP_SUB:  alu_res = bus.rega - bus.regb;
            OP_AND:  alu_res = bus.rega & bus.regb;
            OP_OR:   alu_res = bus.rega | bus.regb;
            OP_XOR:  alu_res = bus.rega ^ bus.regb;
            OP_SLL:  alu_res = bus.rega << shamt;
            OP_SRL:  alu_res = bus.rega >> shamt;
            OP_SRA:  alu_res = DATA_W'($signed(bus.rega) >>> shamt);
            OP_LUI:  alu_res = bus.rega << (DATA_W / 2);
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(bus.rega) < $signed(bus.regb)};
            OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, bus.rega < bus.regb};
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    // Iterative MUL/DIV datapath sharing one 2*DATA_W work register.
    // MUL: acc = {partial high, remaining multiplier bits}, shifted right.
    // DIV: acc = {remainder, remaining dividend / quotient bits}, shifted left.
    // Divide by zero falls out naturally: every trial succeeds (quotient all
    // ones) and the remainder ends up holding the dividend.
    always_comb begin
        mul_sum     = acc_q[0] ? ({1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, opb_q})
                               : {1'b0, acc_q[2*DATA_W-1:DATA_W]};
        div_shifted = acc_q[2*DATA_W-1:DATA_W-1];
        div_ge      = div_shifted >= {1'b0, opb_q};
        div_rem     = div_ge ? (div_shifted[DATA_W-1:0] - opb_q) : div_shifted[DATA_W-1:0];

        acc_d = acc_q;
        opb_d = opb_q;
        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (accept && is_long) begin
            acc_d = {{DATA_W{1'b0}}, bus.rega};
            opb_d = bus.regb;
            cnt_d = CNT_W'(DATA_W);
        end else if (state_q == S_MUL) begin
            acc_d = {mul_sum, acc_q[DATA_W-1:1]};
            cnt_d = cnt_q - CNT_W'(1);
        end else if (state_q == S_DIV) begin
            acc_d = {div_rem, acc_q[DATA_W-2:0], div_ge};
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (last_iter) begin
            hi_d = acc_d[2*DATA_W-1:DATA_W];
            lo_d = acc_d[DATA_W-1:0];
        end
    end

    // Output token: load on short-op acceptance, otherwise drain on out_ready
    always_comb begin
        out_valid_d = out_valid_q;
        regc_data_d = regc_data_q;
        regc_addr_d = regc_addr_q;
        regc_wr_d   = regc_wr_q;
        if (accept && !is_long) begin
            out_valid_d = 1'b1;
            if (bus.op == OP_NOP) begin
                regc_data_d = '0;
                regc_addr_d = '0;
                regc_wr_d   = 1'b0;
            end else begin
                regc_data_d = alu_res;
                regc_addr_d = bus.waddr_i;
                regc_wr_d   = bus.wr_i && (bus.waddr_i != '0);
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            opb_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            out_valid_q <= 1'b0;
            regc_data_q <= '0;
            regc_addr_q <= '0;
            regc_wr_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            opb_q       <= opb_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            out_valid_q <= out_valid_d;
            regc_data_q <= regc_data_d;
            regc_addr_q <= regc_addr_d;
            regc_wr_q   <= regc_wr_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.regc_data = regc_data_q;
    assign bus.regc_addr = regc_addr_q;
    assign bus.regc_wr   = regc_wr_q;
endmodule

// File: tb/tb_ex_pipe.sv
// Directed bench for ex_pipe: ALU vectors, MULTU/DIVU timing and results,
// output backpressure and reset abort of a long op.
module tb_ex_pipe;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ex_pipe_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    ex_pipe #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one op for a single edge with the output side draining
    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic w, input logic [4:0] ad);
        bus.in_valid  = 1'b1;
        bus.op        = o;
        bus.rega      = a;
        bus.regb      = b;
        bus.wr_i      = w;
        bus.waddr_i   = ad;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.op = 4'd0; bus.rega = '0; bus.regb = '0;
        bus.wr_i = 1'b0; bus.waddr_i = '0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
        end
        checks++;
        if ({bus.out_valid, bus.regc_data, bus.regc_addr, bus.regc_wr} !== 39'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h a=%h w=%b expected all zero",
                     bus.out_valid, bus.regc_data, bus.regc_addr, bus.regc_wr);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_alu();
        logic [3:0]  t_op [14];
        logic [31:0] t_a  [14];
        logic [31:0] t_b  [14];
        logic        t_w  [14];
        logic [4:0]  t_ad [14];
        logic [31:0] e_d  [14];
        logic [4:0]  e_ad [14];
        logic        e_w  [14];
        t_op = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd8, 4'd9, 4'd10, 4'd11, 4'd0, 4'd1};
        t_a  = '{32'hFFFFFFFF, 32'd5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'd1,
                 32'h80000000, 32'h80000000, 32'h80000000, 32'h00001234, 32'hFFFFFFFF,
                 32'hFFFFFFFF, 32'h12345678, 32'd4};
        t_b  = '{32'd2, 32'd7, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'h00000021,
                 32'h0000001F, 32'h00000024, 32'h00000020, 32'd0, 32'd1, 32'd1, 32'd1, 32'd4};
        t_w  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        t_ad = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16};
        e_d  = '{32'h00000001, 32'hFFFFFFFE, 32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'd2,
                 32'd1, 32'hF8000000, 32'h80000000, 32'h12340000, 32'd1, 32'd0, 32'd0, 32'd8};
        e_ad = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd16};
        e_w  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 14; i++) begin
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL alu_ready[%0d]: got %b expected 1", i, bus.in_ready);
            end
            do_op(t_op[i], t_a[i], t_b[i], t_w[i], t_ad[i]);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.regc_data !== e_d[i] ||
                bus.regc_addr !== e_ad[i] || bus.regc_wr !== e_w[i]) begin
                errors++;
                $display("FAIL alu[%0d] op=%0d: got v=%b d=%h a=%0d w=%b expected v=1 d=%h a=%0d w=%b",
                         i, t_op[i], bus.out_valid, bus.regc_data, bus.regc_addr, bus.regc_wr,
                         e_d[i], e_ad[i], e_w[i]);
            end
        end
    endtask

    task automatic test_mul();
        int busy;
        do_op(4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5'd1);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL mul_no_token: got out_valid=%b expected 0", bus.out_valid);
        end
        busy = 0;
        while (bus.in_ready === 1'b0 && busy < 40) begin
            busy++;
            @(negedge clk);
        end
        checks++;
        if (busy != 32) begin
            errors++; $display("FAIL mul_busy_cycles: got %0d expected 32", busy);
        end
        do_op(4'd14, 32'd0, 32'd0, 1'b1, 5'd2);
        checks++;
        if (bus.regc_data !== 32'hFFFFFFFE || bus.regc_wr !== 1'b1) begin
            errors++; $display("FAIL mul_hi: got %h expected fffffffe", bus.regc_data);
        end
        do_op(4'd15, 32'd0, 32'd0, 1'b1, 5'd2);
        checks++;
        if (bus.regc_data !== 32'h00000001) begin
            errors++; $display("FAIL mul_lo: got %h expected 00000001", bus.regc_data);
        end
    endtask

    task automatic test_div();
        logic [31:0] d_a [2];
        logic [31:0] d_b [2];
        logic [31:0] e_lo [2];
        logic [31:0] e_hi [2];
        int busy;
        d_a  = '{32'd100, 32'd5};
        d_b  = '{32'd7, 32'd0};
        e_lo = '{32'd14, 32'hFFFFFFFF};
        e_hi = '{32'd2, 32'd5};
        for (int i = 0; i < 2; i++) begin
            do_op(4'd13, d_a[i], d_b[i], 1'b1, 5'd1);
            busy = 0;
            while (bus.in_ready === 1'b0 && busy < 40) begin
                busy++;
                @(negedge clk);
            end
            checks++;
            if (busy != 32) begin
                errors++; $display("FAIL div_busy_cycles[%0d]: got %0d expected 32", i, busy);
            end
            do_op(4'd15, 32'd0, 32'd0, 1'b1, 5'd3);
            checks++;
            if (bus.regc_data !== e_lo[i]) begin
                errors++; $display("FAIL div_lo[%0d]: got %h expected %h", i, bus.regc_data, e_lo[i]);
            end
            do_op(4'd14, 32'd0, 32'd0, 1'b1, 5'd3);
            checks++;
            if (bus.regc_data !== e_hi[i]) begin
                errors++; $display("FAIL div_hi[%0d]: got %h expected %h", i, bus.regc_data, e_hi[i]);
            end
        end
        // HI/LO must survive ordinary ALU traffic
        do_op(4'd1, 32'd9, 32'd9, 1'b1, 5'd4);
        do_op(4'd15, 32'd0, 32'd0, 1'b1, 5'd3);
        checks++;
        if (bus.regc_data !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL lo_preserved: got %h expected ffffffff", bus.regc_data);
        end
    endtask

    task automatic test_backpressure();
        do_op(4'd1, 32'd10, 32'd20, 1'b1, 5'd7);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.regc_data !== 32'd30 || bus.regc_addr !== 5'd7 ||
                bus.regc_wr !== 1'b1 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: got v=%b d=%h a=%0d w=%b rdy=%b expected v=1 d=0000001e a=7 w=1 rdy=0",
                         i, bus.out_valid, bus.regc_data, bus.regc_addr, bus.regc_wr, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op        = 4'd2;
        bus.rega      = 32'd30;
        bus.regb      = 32'd10;
        bus.wr_i      = 1'b1;
        bus.waddr_i   = 5'd9;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL drain_ready: got %b expected 1", bus.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.regc_data !== 32'd20 || bus.regc_addr !== 5'd9) begin
            errors++;
            $display("FAIL drain_next: got v=%b d=%h a=%0d expected v=1 d=00000014 a=9",
                     bus.out_valid, bus.regc_data, bus.regc_addr);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL drain_clear: got out_valid=%b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid_mul();
        do_op(4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5'd1);
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL mid_rst_ready: got %b expected 0", bus.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_rst_release: got %b expected 1", bus.in_ready);
        end
        do_op(4'd14, 32'd0, 32'd0, 1'b1, 5'd5);
        checks++;
        if (bus.regc_data !== 32'd0) begin
            errors++; $display("FAIL mid_rst_hi: got %h expected 00000000", bus.regc_data);
        end
        do_op(4'd15, 32'd0, 32'd0, 1'b1, 5'd5);
        checks++;
        if (bus.regc_data !== 32'd0) begin
            errors++; $display("FAIL mid_rst_lo: got %h expected 00000000", bus.regc_data);
        end
        do_op(4'd1, 32'd1, 32'd2, 1'b1, 5'd0);
        checks++;
        if (bus.regc_wr !== 1'b0 || bus.regc_data !== 32'd3 || bus.regc_addr !== 5'd0) begin
            errors++;
            $display("FAIL addr0_wr: got w=%b d=%h a=%0d expected w=0 d=00000003 a=0",
                     bus.regc_wr, bus.regc_data, bus.regc_addr);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        @(negedge clk);
        test_reset();
        test_alu();
        test_mul();
        test_div();
        test_backpressure();
        test_reset_mid_mul();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
